// File: rtl/speculative_output_commit_buffer_if.sv
// rtl/speculative_output_commit_buffer_if.sv - write and drain handshake bundle for the speculative commit buffer
interface speculative_output_commit_buffer_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int TAG_WIDTH     = 3,
  parameter int CHANNEL_WIDTH = 2
);
  logic                     write_valid;
  logic                     write_speculative;
  logic [CHANNEL_WIDTH-1:0] write_channel;
  logic [TAG_WIDTH-1:0]     write_tag;
  logic [WORD_WIDTH-1:0]    write_data;
  logic                     write_ready;

  logic                     out_valid;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic [TAG_WIDTH-1:0]     out_tag;
  logic [WORD_WIDTH-1:0]    out_data;
  logic                     out_ready;

  // Datapath / channel-network side.
  modport master (
    output write_valid, write_speculative, write_channel, write_tag, write_data,
    input  write_ready,
    input  out_valid, out_channel, out_tag, out_data,
    output out_ready
  );

  // Buffer side.
  modport slave (
    input  write_valid, write_speculative, write_channel, write_tag, write_data,
    output write_ready,
    output out_valid, out_channel, out_tag, out_data,
    input  out_ready
  );
endinterface

// File: rtl/speculative_output_commit_buffer.sv
// rtl/speculative_output_commit_buffer.sv - holds speculative output-channel writes until commit, squashes on miss
module speculative_output_commit_buffer #(
  parameter int DEPTH         = 4,
  parameter int WORD_WIDTH    = 32,
  parameter int TAG_WIDTH     = 3,
  parameter int CHANNEL_WIDTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          predicate_prediction_hit,
  input  logic          predicate_prediction_miss,
  speculative_output_commit_buffer_if.slave bus,
  output logic [OW-1:0] occupancy,
  output logic [OW-1:0] speculative_count,
  output logic          order_error
);

  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [OW-1:0]            occ;
  logic [OW-1:0]            spec_cnt;
  logic [DEPTH-1:0]         spec_bits;
  logic                     err;

  logic [CHANNEL_WIDTH-1:0] chan_mem [DEPTH];
  logic [TAG_WIDTH-1:0]     tag_mem  [DEPTH];
  logic [WORD_WIDTH-1:0]    data_mem [DEPTH];

  logic                     accept;
  logic                     drain;
  logic                     hit_eff;
  logic                     miss_eff;
  logic                     store;
  logic                     order_violation;
  logic [OW-1:0]            squash;
  logic [PW-1:0]            store_ptr;
  logic [OW-1:0]            occ_next;
  logic [OW-1:0]            spec_cnt_next;
  logic [DEPTH-1:0]         spec_bits_next;

  assign bus.write_ready = enable && (occ < OW'(DEPTH));
  assign bus.out_valid   = enable && (occ != '0) && !spec_bits[head];
  assign bus.out_channel = chan_mem[head];
  assign bus.out_tag     = tag_mem[head];
  assign bus.out_data    = data_mem[head];

  assign occupancy         = occ;
  assign speculative_count = spec_cnt;
  assign order_error       = err;

  always_comb begin
    accept   = bus.write_valid && bus.write_ready;
    drain    = bus.out_valid && bus.out_ready;
    // Miss dominates a simultaneous hit.
    miss_eff = enable && predicate_prediction_miss;
    hit_eff  = enable && predicate_prediction_hit && !predicate_prediction_miss;
    // A speculative write arriving with a miss belongs to the squashed section.
    store    = accept && !(miss_eff && bus.write_speculative);
    squash   = miss_eff ? spec_cnt : '0;
    // Rewinding the tail first lets a same-cycle write land right after the survivors.
    store_ptr = tail - squash[PW-1:0];

    occ_next = occ + OW'(store) - OW'(drain) - squash;

    spec_cnt_next = (hit_eff || miss_eff) ? '0 : spec_cnt;
    spec_cnt_next = spec_cnt_next + OW'(store && bus.write_speculative);

    spec_bits_next = hit_eff ? '0 : spec_bits;
    if (store) begin
      spec_bits_next[store_ptr] = bus.write_speculative;
    end

    order_violation = accept && !bus.write_speculative && (spec_cnt != '0)
                      && !predicate_prediction_hit && !predicate_prediction_miss;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      spec_cnt  <= '0;
      spec_bits <= '0;
      err       <= 1'b0;
    end else if (enable) begin
      if (drain) begin
        head <= head + PW'(1);
      end
      tail      <= store_ptr + PW'(store);
      occ       <= occ_next;
      spec_cnt  <= spec_cnt_next;
      spec_bits <= spec_bits_next;
      if ((predicate_prediction_hit && predicate_prediction_miss) || order_violation) begin
        err <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: an entry is only offered once written.
  always_ff @(posedge clock) begin
    if (!reset && store) begin
      chan_mem[store_ptr] <= bus.write_channel;
      tag_mem[store_ptr]  <= bus.write_tag;
      data_mem[store_ptr] <= bus.write_data;
    end
  end

endmodule

// File: tb/tb_speculative_output_commit_buffer.sv
// tb/tb_speculative_output_commit_buffer.sv - directed bench with queue-based reference model
module tb_speculative_output_commit_buffer;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       hit;
  logic       miss;
  logic [2:0] occupancy;
  logic [2:0] speculative_count;
  logic       order_error;

  speculative_output_commit_buffer_if bus ();

  speculative_output_commit_buffer dut (
    .clock                     (clock),
    .reset                     (reset),
    .enable                    (enable),
    .predicate_prediction_hit  (hit),
    .predicate_prediction_miss (miss),
    .bus                       (bus),
    .occupancy                 (occupancy),
    .speculative_count         (speculative_count),
    .order_error               (order_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        spec;
    logic [1:0]  ch;
    logic [2:0]  tag;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_err;
  logic [31:0] log_q[$];
  int          checks;
  int          failures;
  bit          started;
  int          ns;
  bit          acc;
  bit          drn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_spec();
    int n = 0;
    foreach (q[i]) if (q[i].spec) n++;
    return n;
  endfunction

  // Reference model: the buffer is an ordered list of entries.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_err = 1'b0;
    end else if (enable) begin
      ns  = count_spec();
      acc = bus.write_valid && (q.size() < DEPTH);
      drn = bus.out_ready && (q.size() != 0) && !q[0].spec;
      if (hit && miss) m_err = 1'b1;
      if (acc && !bus.write_speculative && ns != 0 && !hit && !miss) m_err = 1'b1;
      if (drn) void'(q.pop_front());
      if (miss) begin
        for (int k = 0; k < ns; k++) if (q.size() != 0) void'(q.pop_back());
      end else if (hit) begin
        foreach (q[i]) q[i].spec = 1'b0;
      end
      if (acc && !(miss && bus.write_speculative))
        q.push_back('{bus.write_speculative, bus.write_channel, bus.write_tag, bus.write_data});
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("write_ready", bus.write_ready, enable && (q.size() < DEPTH));
      check("out_valid", bus.out_valid, enable && (q.size() != 0) && !q[0].spec);
      check("occupancy", occupancy, q.size());
      check("speculative_count", speculative_count, count_spec());
      check("order_error", order_error, m_err);
      if (enable && q.size() != 0 && !q[0].spec) begin
        check("out_data", bus.out_data, q[0].data);
        check("out_tag", bus.out_tag, q[0].tag);
        check("out_channel", bus.out_channel, q[0].ch);
      end
      if (!reset && bus.out_valid && bus.out_ready) log_q.push_back(bus.out_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic spec, input logic [31:0] d);
    bus.write_valid       = 1'b1;
    bus.write_speculative = spec;
    bus.write_data        = d;
    bus.write_channel     = d[1:0];
    bus.write_tag         = d[4:2];
    tick();
    bus.write_valid       = 1'b0;
    bus.write_speculative = 1'b0;
  endtask

  task automatic resolve(input logic h, input logic m);
    hit  = h;
    miss = m;
    tick();
    hit  = 1'b0;
    miss = 1'b0;
  endtask

  task automatic expect_log(input string name, input int n, input logic [31:0] e0,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3, input logic [31:0] e4);
    logic [31:0] e[5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) check(name, log_q[i], e[i]);
    log_q.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    started  = 1'b0;
    reset    = 1'b1;
    enable   = 1'b1;
    hit      = 1'b0;
    miss     = 1'b0;
    bus.write_valid       = 1'b0;
    bus.write_speculative = 1'b0;
    bus.write_channel     = '0;
    bus.write_tag         = '0;
    bus.write_data        = '0;
    bus.out_ready         = 1'b0;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_write_ready", bus.write_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_occupancy", occupancy, 0);

    // 1: plain in-order drain
    bus.out_ready = 1'b1;
    wr(0, 32'hA); wr(0, 32'hB); wr(0, 32'hC);
    repeat (3) tick();
    expect_log("t1_drain", 3, 32'hA, 32'hB, 32'hC, 0, 0);
    check("t1_occupancy", occupancy, 0);

    // 2: speculative entries wait for hit
    wr(1, 32'h1); wr(1, 32'h2);
    check("t2_held", bus.out_valid, 0);
    check("t2_spec", speculative_count, 2);
    resolve(1, 0);
    check("t2_head_after_hit", bus.out_data, 32'h1);
    repeat (3) tick();
    expect_log("t2_drain", 2, 32'h1, 32'h2, 0, 0, 0);

    // enable low freezes everything
    bus.out_ready = 1'b0;
    wr(0, 32'h50);
    enable = 1'b0;
    bus.out_ready = 1'b1;
    bus.write_valid = 1'b1;
    bus.write_data = 32'h51;
    hit = 1'b1;
    repeat (2) tick();
    check("en_occupancy", occupancy, 1);
    check("en_out_valid", bus.out_valid, 0);
    check("en_write_ready", bus.write_ready, 0);
    enable = 1'b1;
    hit = 1'b0;
    bus.write_valid = 1'b0;
    repeat (2) tick();
    expect_log("en_drain", 1, 32'h50, 0, 0, 0, 0);

    // 3: miss squashes the speculative tail, drops a same-cycle speculative write
    bus.out_ready = 1'b0;
    wr(0, 32'h5); wr(1, 32'h6); wr(1, 32'h7);
    check("t3_occupancy", occupancy, 3);
    check("t3_spec", speculative_count, 2);
    bus.write_valid = 1'b1;
    bus.write_speculative = 1'b1;
    bus.write_data = 32'h77;
    resolve(0, 1);
    bus.write_valid = 1'b0;
    bus.write_speculative = 1'b0;
    check("t3_occ_after_miss", occupancy, 1);
    check("t3_spec_after_miss", speculative_count, 0);
    bus.out_ready = 1'b1;
    wr(0, 32'h8);
    repeat (3) tick();
    expect_log("t3_drain", 2, 32'h5, 32'h8, 0, 0, 0);

    // 4: full buffer refuses a write even while draining
    bus.out_ready = 1'b0;
    wr(0, 32'h10); wr(0, 32'h11); wr(0, 32'h12); wr(0, 32'h13);
    check("t4_full_ready", bus.write_ready, 0);
    check("t4_full_occ", occupancy, 4);
    bus.write_valid = 1'b1;
    bus.write_data = 32'h14;
    bus.out_ready = 1'b1;
    #1;
    check("t4_refused", bus.write_ready, 0);
    tick();
    check("t4_ready_next", bus.write_ready, 1);
    check("t4_occ_next", occupancy, 3);
    tick();
    bus.write_valid = 1'b0;
    repeat (4) tick();
    expect_log("t4_drain", 5, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14);

    // 5: hit with a same-cycle speculative write; later miss with a same-cycle committed write
    bus.out_ready = 1'b0;
    wr(1, 32'h20); wr(1, 32'h21);
    bus.write_valid = 1'b1;
    bus.write_speculative = 1'b1;
    bus.write_data = 32'h9;
    resolve(1, 0);
    bus.write_valid = 1'b0;
    bus.write_speculative = 1'b0;
    check("t5_spec", speculative_count, 1);
    check("t5_occ", occupancy, 3);
    bus.write_valid = 1'b1;
    bus.write_data = 32'h22;
    resolve(0, 1);
    bus.write_valid = 1'b0;
    check("t5_occ_after_miss", occupancy, 3);
    check("t5_order_error", order_error, 0);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    expect_log("t5_drain", 3, 32'h20, 32'h21, 32'h22, 0, 0);

    // 6: simultaneous hit/miss flags an error; reset clears everything
    bus.out_ready = 1'b0;
    wr(0, 32'h30); wr(0, 32'h31); wr(1, 32'h32);
    resolve(1, 1);
    check("t6_both_error", order_error, 1);
    check("t6_occ_squash", occupancy, 2);
    wr(1, 32'h34);
    check("t6_occ", occupancy, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_reset_occ", occupancy, 0);
    check("t6_reset_valid", bus.out_valid, 0);
    check("t6_reset_error", order_error, 0);
    check("t6_reset_ready", bus.write_ready, 1);

    // committed write behind a speculative one violates ordering
    wr(1, 32'h40); wr(0, 32'h41);
    check("t7_order_error", order_error, 1);
    check("t7_occ", occupancy, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    log_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
